// File: rtl/log_norm_calc.sv
// log_norm_calc: leading-one normaliser for the log-compression front end.
//
// Takes an unsigned DATA_WIDTH-bit sample and returns:
//   exp_out   - bit index p of the leading one
//   norm_out  - 1.FRAC_WIDTH mantissa, i.e. data_in[p -: NORM_WIDTH] (zero-filled below bit 0)
//   zero_flag - sample was zero (norm_out then reads 1.0, exp_out 0)
// The leading-one search is a binary shift search: one step per cycle, shift amounts
// 2^(S-1) down to 1, so every sample takes exactly S SHIFT cycles.
//
// Ports:
//   clk, reset          - single clock; synchronous active-high reset
//   in_valid/in_ready   - input handshake; in_ready is high only while idle
//   data_in             - sample, captured on the accept edge only
//   out_valid/out_ready - output handshake; result held stable until consumed
//   norm_out, exp_out, zero_flag - registered result
module log_norm_calc #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned FRAC_WIDTH = 16,
  parameter int unsigned NORM_WIDTH = FRAC_WIDTH + 1,
  parameter int unsigned EXP_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NORM_WIDTH-1:0] norm_out,
  output logic [EXP_WIDTH-1:0]  exp_out,
  output logic                  zero_flag
);

  localparam int unsigned S  = $clog2(DATA_WIDTH);
  localparam int unsigned KW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] v_q;
  logic [EXP_WIDTH-1:0]  lz_q;
  logic [KW-1:0]         k_q;
  logic                  zero_q;

  logic [31:0]           shift_amt;
  logic [DATA_WIDTH-1:0] top_mask;
  logic [DATA_WIDTH-1:0] v_step;
  logic [EXP_WIDTH-1:0]  lz_step;
  logic [EXP_WIDTH-1:0]  p_step;
  logic [NORM_WIDTH-1:0] norm_step;

  assign in_ready = (state_q == StIdle);

  // One search step: shift left by 2^k when the top 2^k bits are clear. Shift amounts that
  // reach the full width are never taken (only matters for non-power-of-two widths).
  always_comb begin
    shift_amt = 32'd1 << k_q;
    top_mask  = ~({DATA_WIDTH{1'b1}} >> shift_amt);
    v_step    = v_q;
    lz_step   = lz_q;
    if ((shift_amt < DATA_WIDTH) && ((v_q & top_mask) == '0)) begin
      v_step  = v_q << shift_amt;
      lz_step = lz_q + EXP_WIDTH'(shift_amt);
    end
    p_step    = EXP_WIDTH'(DATA_WIDTH - 1) - lz_step;
    // After the last step the leading one sits in the MSB, so the mantissa is the top slice.
    norm_step = v_step[DATA_WIDTH-1 -: NORM_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      v_q       <= '0;
      lz_q      <= '0;
      k_q       <= '0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
      norm_out  <= '0;
      exp_out   <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            v_q     <= data_in;
            lz_q    <= '0;
            k_q     <= KW'(S - 1);
            zero_q  <= (data_in == '0);
            state_q <= StShift;
          end
        end
        StShift: begin
          v_q  <= v_step;
          lz_q <= lz_step;
          if (k_q == '0) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
            if (zero_q) begin
              // Mantissa of exactly 1.0 makes the downstream fractional log zero.
              norm_out  <= {1'b1, {FRAC_WIDTH{1'b0}}};
              exp_out   <= '0;
              zero_flag <= 1'b1;
            end else begin
              norm_out  <= norm_step;
              exp_out   <= p_step;
              zero_flag <= 1'b0;
            end
          end else begin
            k_q <= k_q - KW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule
